// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter and its companion receiver.
// Holds the data width, the FSM state encodings and the idle line level,
// plus a small even-parity helper used when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic UART_IDLE = 1'b1;

  function automatic logic evenParity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Counts 0..div-1 and raises tick during the last clock of each bit period.
// clr forces the count back to zero so a new bit period starts cleanly.
module uart_baud_gen #(
  parameter int div = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (div > 1) ? $clog2(div) : 1;
  localparam logic [CW-1:0] LAST = CW'(div - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap at the end of a bit period or whenever a clear is requested
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-byte holding register so the
// producer can queue the next byte while the current frame is shifting.
// Consecutive frames are sent with no idle gap between stop and start bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int div = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       req,
  output logic       ack,
  output logic       txd,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [2:0] state_q,    state_d;
  logic [7:0] shifter_q,  shifter_d;
  logic [7:0] hold_q,     hold_d;
  logic       holdFull_q, holdFull_d;
  logic       ack_q,      ack_d;
  logic       txd_q,      txd_d;
  logic [2:0] bitCnt_q,   bitCnt_d;
`ifdef UART_TX_PARITY_EN
  logic       parity_q,   parity_d;
`endif

  logic tick;
  logic capture;
  logic loadFrame;

  // The baud counter is held at zero while idle, so the start bit of a
  // frame launched from idle gets a full period; inside a frame every state
  // change happens on tick, where the counter wraps to zero anyway.
  uart_baud_gen #(
    .div(div)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .tick(tick)
  );

  // A held req must not be captured twice, hence the ack_q qualifier.
  assign capture = req && !holdFull_q && !ack_q;

  // Handshake, holding register, frame sequencing and shifting
  always_comb begin
    state_d    = state_q;
    shifter_d  = shifter_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    bitCnt_d   = bitCnt_q;
    ack_d      = capture;
    loadFrame  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (holdFull_q) begin
          loadFrame = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shifter_d = shifter_q >> 1;
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = ST_PARITY;
`else
            state_d  = ST_STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (holdFull_q) begin
            loadFrame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Capture needs an empty holding register and a load needs a full one,
    // so the two never collide on the same edge.
    if (loadFrame) begin
      state_d    = ST_START;
      shifter_d  = hold_q;
      holdFull_d = 1'b0;
      bitCnt_d   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d   = evenParity(hold_q);
`endif
    end

    if (capture) begin
      hold_d     = data;
      holdFull_d = 1'b1;
    end
  end

  // Line level for the state being entered, so txd can be a plain register
  always_comb begin
    txd_d = UART_IDLE;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shifter_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = UART_IDLE;
    endcase
  end

  // State registers; reset drops any frame in flight and empties the holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shifter_q  <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      ack_q      <= 1'b0;
      txd_q      <= UART_IDLE;
      bitCnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shifter_q  <= shifter_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      ack_q      <= ack_d;
      txd_q      <= txd_d;
      bitCnt_q   <= bitCnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign ack  = ack_q;
  assign txd  = txd_q;
  assign busy = (state_q != ST_IDLE) | holdFull_q;

endmodule
